// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter in front of the SDRAM controller.
// Holds the FSM state encoding, the Wishbone cycle-type tags and the timeout counter width.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BUSY  = 2'b01,
    ST_DRAIN = 2'b10
  } arb_state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Wide enough for the largest legal TIMEOUT (65535).
  localparam int CNT_W = 16;

endpackage

// File: rtl/wb_arb_rr2.sv
// Two-way request picker: single requester wins outright, a tie goes to the master
// not granted last (round-robin) or always to m0 when FIXED_PRIO is set.
module wb_arb_rr2 #(
  parameter int FIXED_PRIO = 0
) (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       valid_o,
  output logic       grant_o
);

  // Combinational pick of the next owner.
  always_comb begin
    valid_o = |req_i;
    grant_o = 1'b0;
    case (req_i)
      2'b01:   grant_o = 1'b0;
      2'b10:   grant_o = 1'b1;
      2'b11:   grant_o = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant_i;
      default: grant_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/wb_sdram_arbiter.sv
// Arbitrates two Wishbone masters onto one SDRAM controller port; the grant is held for a whole
// cycle and a stalled access is aborted with err after TIMEOUT cycles of unanswered strobe.
module wb_sdram_arbiter
  import wb_arb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int TIMEOUT    = 1024,
  parameter int FIXED_PRIO = 0
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  input  logic [AW-1:0]     m0_adr_i,
  input  logic [DW-1:0]     m0_dat_i,
  input  logic [DW/8-1:0]   m0_sel_i,
  input  logic              m0_we_i,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic [2:0]        m0_cti_i,
  input  logic [1:0]        m0_bte_i,
  output logic [DW-1:0]     m0_dat_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  input  logic [AW-1:0]     m1_adr_i,
  input  logic [DW-1:0]     m1_dat_i,
  input  logic [DW/8-1:0]   m1_sel_i,
  input  logic              m1_we_i,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic [2:0]        m1_cti_i,
  input  logic [1:0]        m1_bte_i,
  output logic [DW-1:0]     m1_dat_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic [AW-1:0]     s_adr_o,
  output logic [DW-1:0]     s_dat_o,
  output logic [DW/8-1:0]   s_sel_o,
  output logic              s_we_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic [2:0]        s_cti_o,
  output logic [1:0]        s_bte_o,
  input  logic [DW-1:0]     s_dat_i,
  input  logic              s_ack_i,
  input  logic              s_err_i,
  output logic [CNT_W-1:0]  timeout_cnt_o
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e       state_q, state_d;
  logic             grant_q, grant_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] tocnt_q, tocnt_d;

  logic             pick_valid_s, pick_s;
  logic             busy_s, term_s, timeout_s;
  logic             g_cyc_s, g_stb_s;

  wb_arb_rr2 #(.FIXED_PRIO(FIXED_PRIO)) u_rr2 (
    .req_i        ({m1_cyc_i, m0_cyc_i}),
    .last_grant_i (last_grant_q),
    .valid_o      (pick_valid_s),
    .grant_o      (pick_s)
  );

  assign busy_s  = (state_q == ST_BUSY);
  assign g_cyc_s = grant_q ? m1_cyc_i : m0_cyc_i;
  assign g_stb_s = grant_q ? m1_stb_i : m0_stb_i;
  assign term_s  = s_ack_i | s_err_i;
  // An ack arriving on the last allowed cycle beats the timeout.
  assign timeout_s = busy_s & g_cyc_s & g_stb_s & ~term_s & (cnt_q == TO_LAST);

  // Slave-side bundle mirrors the owner only while BUSY; everything is zero otherwise.
  always_comb begin
    s_cyc_o = busy_s & g_cyc_s & ~timeout_s;
    s_stb_o = busy_s & g_stb_s & ~timeout_s;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cti_o = 3'b000;
    s_bte_o = 2'b00;
    if (busy_s) begin
      s_adr_o = grant_q ? m1_adr_i : m0_adr_i;
      s_dat_o = grant_q ? m1_dat_i : m0_dat_i;
      s_sel_o = grant_q ? m1_sel_i : m0_sel_i;
      s_we_o  = grant_q ? m1_we_i  : m0_we_i;
      s_cti_o = grant_q ? m1_cti_i : m0_cti_i;
      s_bte_o = grant_q ? m1_bte_i : m0_bte_i;
    end else begin
      s_adr_o = '0;
    end
  end

  // Response routing: only the granted master ever sees data or termination.
  always_comb begin
    m0_dat_o = (busy_s & ~grant_q) ? s_dat_i : '0;
    m1_dat_o = (busy_s &  grant_q) ? s_dat_i : '0;
    m0_ack_o = busy_s & ~grant_q & s_ack_i;
    m1_ack_o = busy_s &  grant_q & s_ack_i;
    m0_err_o = busy_s & ~grant_q & (s_err_i | timeout_s);
    m1_err_o = busy_s &  grant_q & (s_err_i | timeout_s);
  end

  assign timeout_cnt_o = tocnt_q;

  // Next-state and counter logic.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    tocnt_d      = tocnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (pick_valid_s) begin
          grant_d = pick_s;
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (!g_cyc_s) begin
          state_d      = ST_IDLE;
          last_grant_d = grant_q;
          cnt_d        = '0;
        end else if (timeout_s) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
          tocnt_d = tocnt_q + CNT_W'(1);
        end else if (term_s || !g_stb_s) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        cnt_d = '0;
        if (!g_cyc_s) begin
          state_d      = ST_IDLE;
          last_grant_d = grant_q;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      tocnt_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      tocnt_q      <= tocnt_d;
    end
  end

endmodule
